// File: rtl/rca_config_sequencer_pkg.sv
// Shared types for the RCA configuration sequencer: command opcodes, the
// buffered command record and the sequencing FSM states.
package rca_config_sequencer_pkg;

  localparam int CMD_OP_W   = 4;
  localparam int CMD_ADDR_W = 8;
  localparam int CMD_DATA_W = 16;

  typedef enum logic [3:0] {
    OP_START    = 4'd0,
    OP_SRC      = 4'd1,
    OP_DEST_FB  = 4'd2,
    OP_DEST_NFB = 4'd3,
    OP_GRID     = 4'd4,
    OP_IO       = 4'd5,
    OP_RES_FB   = 4'd6,
    OP_RES_NFB  = 4'd7,
    OP_IO_MAP   = 4'd8,
    OP_END      = 4'd9
  } cfg_op_t;

  // op is kept as raw bits so illegal opcodes can be buffered and then rejected
  typedef struct packed {
    logic [CMD_OP_W-1:0]   op;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
  } cfg_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_IDLE = 2'd1,
    ST_STREAM    = 2'd2,
    ST_COMMIT    = 2'd3
  } cfg_state_t;

  function automatic logic is_write_op(input logic [CMD_OP_W-1:0] op);
    return (op >= OP_SRC) && (op <= OP_IO_MAP);
  endfunction

endpackage

// File: rtl/rca_config_sequencer_if.sv
// Command handshake between the CPU-side RCA config unit (master) and the
// configuration sequencer (slave).
interface rca_config_sequencer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/rca_config_sequencer_cmd_fifo.sv
// Small command buffer; pointers carry an extra wrap bit so full and empty
// are distinguished without a separate occupancy counter.
module rca_cfg_cmd_fifo
  import rca_config_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  cfg_cmd_t wdata_i,
  input  logic     pop_i,
  output cfg_cmd_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  cfg_cmd_t    mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer and storage update; overflow/underflow requests are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/rca_config_sequencer.sv
// Turns a buffered stream of config commands into single-cycle config-register
// write strobes, holding the target RCA busy until the sequence commits.
module rca_config_sequencer
  import rca_config_sequencer_pkg::*;
#(
  parameter int NUM_RCAS           = 4,
  parameter int NUM_READ_PORTS     = 2,
  parameter int NUM_WRITE_PORTS    = 2,
  parameter int NUM_GRID_MUXES     = 64,
  parameter int GRID_MUX_INPUTS    = 16,
  parameter int GRID_NUM_ROWS      = 4,
  parameter int IO_UNIT_MUX_INPUTS = 8,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  rca_config_sequencer_if.slave                  cmd,
  input  logic [NUM_RCAS-1:0]                    rca_idle,
  output logic [$clog2(NUM_RCAS)-1:0]            cfg_rca_sel,
  output logic                                   cpu_fb_reg_addr_wr_en,
  output logic                                   cpu_nfb_reg_addr_wr_en,
  output logic [$clog2(NUM_READ_PORTS)-1:0]      cpu_port_sel,
  output logic                                   cpu_src_dest_port,
  output logic [4:0]                             cpu_reg_addr,
  output logic                                   grid_mux_wr_en,
  output logic [$clog2(NUM_GRID_MUXES)-1:0]      grid_mux_wr_addr,
  output logic [$clog2(GRID_MUX_INPUTS)-1:0]     new_grid_mux_sel,
  output logic                                   io_mux_wr_en,
  output logic [$clog2(GRID_NUM_ROWS)-1:0]       io_mux_addr,
  output logic [$clog2(IO_UNIT_MUX_INPUTS)-1:0]  new_io_mux_sel,
  output logic                                   rca_fb_result_mux_wr_en,
  output logic                                   rca_nfb_result_mux_wr_en,
  output logic [$clog2(NUM_WRITE_PORTS)-1:0]     rca_result_mux_addr,
  output logic [$clog2(GRID_NUM_ROWS)-1:0]       new_rca_result_mux_sel,
  output logic                                   rca_io_inp_map_wr_en,
  output logic [GRID_NUM_ROWS-1:0]               new_rca_io_inp_map,
  output logic [NUM_RCAS-1:0]                    rca_cfg_busy,
  output logic                                   cfg_done,
  output logic                                   cfg_error
);

  localparam int ID_W    = $clog2(NUM_RCAS);
  localparam int PORT_W  = $clog2(NUM_READ_PORTS);
  localparam int RES_W   = $clog2(NUM_WRITE_PORTS);
  localparam int GADDR_W = $clog2(NUM_GRID_MUXES);
  localparam int GSEL_W  = $clog2(GRID_MUX_INPUTS);
  localparam int ROW_W   = $clog2(GRID_NUM_ROWS);
  localparam int IOSEL_W = $clog2(IO_UNIT_MUX_INPUTS);

  cfg_cmd_t   wdata_s;
  cfg_cmd_t   head_s;
  logic       push_s;
  logic       pop_s;
  logic       full_s;
  logic       empty_s;
  logic       unused_s;

  cfg_state_t                  state_q;
  logic [ID_W-1:0]             id_q;
  logic [NUM_RCAS-1:0]         busy_q;
  logic                        done_q;
  logic                        err_q;
  logic                        fb_wr_q;
  logic                        nfb_wr_q;
  logic [PORT_W-1:0]           port_sel_q;
  logic                        src_dest_q;
  logic [4:0]                  reg_addr_q;
  logic                        grid_wr_q;
  logic [GADDR_W-1:0]          grid_addr_q;
  logic [GSEL_W-1:0]           grid_sel_q;
  logic                        io_wr_q;
  logic [ROW_W-1:0]            io_addr_q;
  logic [IOSEL_W-1:0]          io_sel_q;
  logic                        res_fb_wr_q;
  logic                        res_nfb_wr_q;
  logic [RES_W-1:0]            res_addr_q;
  logic [ROW_W-1:0]            res_sel_q;
  logic                        map_wr_q;
  logic [GRID_NUM_ROWS-1:0]    map_q;

  assign wdata_s       = {cmd.cmd_op, cmd.cmd_addr, cmd.cmd_data};
  assign push_s        = cmd.cmd_valid && !full_s;
  assign cmd.cmd_ready = !full_s;
  assign pop_s         = !empty_s && ((state_q == ST_IDLE) || (state_q == ST_STREAM));
  assign unused_s      = ^head_s;

  rca_cfg_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .wdata_i (wdata_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Sequencing FSM; strobes and cfg_done default low so each lasts one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      id_q         <= '0;
      busy_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      fb_wr_q      <= 1'b0;
      nfb_wr_q     <= 1'b0;
      port_sel_q   <= '0;
      src_dest_q   <= 1'b0;
      reg_addr_q   <= 5'd0;
      grid_wr_q    <= 1'b0;
      grid_addr_q  <= '0;
      grid_sel_q   <= '0;
      io_wr_q      <= 1'b0;
      io_addr_q    <= '0;
      io_sel_q     <= '0;
      res_fb_wr_q  <= 1'b0;
      res_nfb_wr_q <= 1'b0;
      res_addr_q   <= '0;
      res_sel_q    <= '0;
      map_wr_q     <= 1'b0;
      map_q        <= '0;
    end else begin
      done_q       <= 1'b0;
      fb_wr_q      <= 1'b0;
      nfb_wr_q     <= 1'b0;
      grid_wr_q    <= 1'b0;
      io_wr_q      <= 1'b0;
      res_fb_wr_q  <= 1'b0;
      res_nfb_wr_q <= 1'b0;
      map_wr_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!empty_s) begin
            if (head_s.op == OP_START) begin
              id_q                            <= head_s.addr[ID_W-1:0];
              busy_q[head_s.addr[ID_W-1:0]]   <= 1'b1;
              state_q                         <= ST_WAIT_IDLE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (rca_idle[id_q]) begin
            state_q <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (!empty_s) begin
            if (head_s.op == OP_END) begin
              state_q <= ST_COMMIT;
            end else if (!is_write_op(head_s.op)) begin
              err_q <= 1'b1;
            end else begin
              case (head_s.op)
                OP_SRC, OP_DEST_FB, OP_DEST_NFB: begin
                  fb_wr_q    <= (head_s.op != OP_DEST_NFB);
                  nfb_wr_q   <= (head_s.op == OP_DEST_NFB);
                  src_dest_q <= (head_s.op != OP_SRC);
                  port_sel_q <= head_s.addr[PORT_W-1:0];
                  reg_addr_q <= head_s.data[4:0];
                end
                OP_GRID: begin
                  grid_wr_q   <= 1'b1;
                  grid_addr_q <= head_s.addr[GADDR_W-1:0];
                  grid_sel_q  <= head_s.data[GSEL_W-1:0];
                end
                OP_IO: begin
                  io_wr_q   <= 1'b1;
                  io_addr_q <= head_s.addr[ROW_W-1:0];
                  io_sel_q  <= head_s.data[IOSEL_W-1:0];
                end
                OP_RES_FB, OP_RES_NFB: begin
                  res_fb_wr_q  <= (head_s.op == OP_RES_FB);
                  res_nfb_wr_q <= (head_s.op == OP_RES_NFB);
                  res_addr_q   <= head_s.addr[RES_W-1:0];
                  res_sel_q    <= head_s.data[ROW_W-1:0];
                end
                OP_IO_MAP: begin
                  map_wr_q <= 1'b1;
                  map_q    <= head_s.data[GRID_NUM_ROWS-1:0];
                end
                default: begin
                  err_q <= 1'b1;
                end
              endcase
            end
          end
        end
        ST_COMMIT: begin
          done_q       <= 1'b1;
          busy_q[id_q] <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_rca_sel              = id_q;
  assign cpu_fb_reg_addr_wr_en    = fb_wr_q;
  assign cpu_nfb_reg_addr_wr_en   = nfb_wr_q;
  assign cpu_port_sel             = port_sel_q;
  assign cpu_src_dest_port        = src_dest_q;
  assign cpu_reg_addr             = reg_addr_q;
  assign grid_mux_wr_en           = grid_wr_q;
  assign grid_mux_wr_addr         = grid_addr_q;
  assign new_grid_mux_sel         = grid_sel_q;
  assign io_mux_wr_en             = io_wr_q;
  assign io_mux_addr              = io_addr_q;
  assign new_io_mux_sel           = io_sel_q;
  assign rca_fb_result_mux_wr_en  = res_fb_wr_q;
  assign rca_nfb_result_mux_wr_en = res_nfb_wr_q;
  assign rca_result_mux_addr      = res_addr_q;
  assign new_rca_result_mux_sel   = res_sel_q;
  assign rca_io_inp_map_wr_en     = map_wr_q;
  assign new_rca_io_inp_map       = map_q;
  assign rca_cfg_busy             = busy_q;
  assign cfg_done                 = done_q;
  assign cfg_error                = err_q;

endmodule

// File: tb/tb_rca_config_sequencer.sv
// Scoreboard bench: expected config writes are queued as commands are pushed
// and matched against each strobe the sequencer emits.
module tb_rca_config_sequencer;
  import rca_config_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rca_idle;
  logic [1:0]  cfg_rca_sel;
  logic        cpu_fb_reg_addr_wr_en, cpu_nfb_reg_addr_wr_en;
  logic [0:0]  cpu_port_sel;
  logic        cpu_src_dest_port;
  logic [4:0]  cpu_reg_addr;
  logic        grid_mux_wr_en;
  logic [5:0]  grid_mux_wr_addr;
  logic [3:0]  new_grid_mux_sel;
  logic        io_mux_wr_en;
  logic [1:0]  io_mux_addr;
  logic [2:0]  new_io_mux_sel;
  logic        rca_fb_result_mux_wr_en, rca_nfb_result_mux_wr_en;
  logic [0:0]  rca_result_mux_addr;
  logic [1:0]  new_rca_result_mux_sel;
  logic        rca_io_inp_map_wr_en;
  logic [3:0]  new_rca_io_inp_map;
  logic [3:0]  rca_cfg_busy;
  logic        cfg_done, cfg_error;

  int          n_chk = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          done_tgt = 0;
  int          snap_wr, snap_done, k_lat;
  logic [31:0] exp_q[$];
  bit          in_seq = 1'b0;
  logic        err_exp = 1'b0;

  always #5 clk = ~clk;

  rca_config_sequencer_if ifc();

  rca_config_sequencer dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .cmd                      (ifc),
    .rca_idle                 (rca_idle),
    .cfg_rca_sel              (cfg_rca_sel),
    .cpu_fb_reg_addr_wr_en    (cpu_fb_reg_addr_wr_en),
    .cpu_nfb_reg_addr_wr_en   (cpu_nfb_reg_addr_wr_en),
    .cpu_port_sel             (cpu_port_sel),
    .cpu_src_dest_port        (cpu_src_dest_port),
    .cpu_reg_addr             (cpu_reg_addr),
    .grid_mux_wr_en           (grid_mux_wr_en),
    .grid_mux_wr_addr         (grid_mux_wr_addr),
    .new_grid_mux_sel         (new_grid_mux_sel),
    .io_mux_wr_en             (io_mux_wr_en),
    .io_mux_addr              (io_mux_addr),
    .new_io_mux_sel           (new_io_mux_sel),
    .rca_fb_result_mux_wr_en  (rca_fb_result_mux_wr_en),
    .rca_nfb_result_mux_wr_en (rca_nfb_result_mux_wr_en),
    .rca_result_mux_addr      (rca_result_mux_addr),
    .new_rca_result_mux_sel   (new_rca_result_mux_sel),
    .rca_io_inp_map_wr_en     (rca_io_inp_map_wr_en),
    .new_rca_io_inp_map       (new_rca_io_inp_map),
    .rca_cfg_busy             (rca_cfg_busy),
    .cfg_done                 (cfg_done),
    .cfg_error                (cfg_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] strobes();
    return {1'b0, rca_io_inp_map_wr_en, rca_nfb_result_mux_wr_en, rca_fb_result_mux_wr_en,
            io_mux_wr_en, grid_mux_wr_en, cpu_nfb_reg_addr_wr_en, cpu_fb_reg_addr_wr_en};
  endfunction

  // Record layout: {strobe vector[7:0], index[7:0], value[14:0], src_dest}
  function automatic logic [31:0] model_rec(input logic [3:0] op, input logic [7:0] a,
                                            input logic [15:0] d);
    logic [7:0]  s;
    logic [7:0]  ea;
    logic [14:0] ed;
    logic        sd;
    s = 8'h00; ea = 8'h00; ed = 15'd0; sd = 1'b0;
    case (op)
      4'd1: begin s = 8'h01; ea = {7'd0, a[0]}; ed = {10'd0, d[4:0]}; end
      4'd2: begin s = 8'h01; ea = {7'd0, a[0]}; ed = {10'd0, d[4:0]}; sd = 1'b1; end
      4'd3: begin s = 8'h02; ea = {7'd0, a[0]}; ed = {10'd0, d[4:0]}; sd = 1'b1; end
      4'd4: begin s = 8'h04; ea = {2'd0, a[5:0]}; ed = {11'd0, d[3:0]}; end
      4'd5: begin s = 8'h08; ea = {6'd0, a[1:0]}; ed = {12'd0, d[2:0]}; end
      4'd6: begin s = 8'h10; ea = {7'd0, a[0]}; ed = {13'd0, d[1:0]}; end
      4'd7: begin s = 8'h20; ea = {7'd0, a[0]}; ed = {13'd0, d[1:0]}; end
      4'd8: begin s = 8'h40; ed = {11'd0, d[3:0]}; end
      default: ;
    endcase
    return {s, ea, ed, sd};
  endfunction

  task automatic sample_writes();
    logic [7:0]  s;
    logic [7:0]  oa;
    logic [14:0] od;
    logic        osd;
    s = strobes(); oa = 8'h00; od = 15'd0; osd = 1'b0;
    if (cfg_done) done_cnt++;
    if (s != 8'h00) begin
      wr_cnt++;
      case (s)
        8'h01, 8'h02: begin oa = {7'd0, cpu_port_sel}; od = {10'd0, cpu_reg_addr}; osd = cpu_src_dest_port; end
        8'h04: begin oa = {2'd0, grid_mux_wr_addr}; od = {11'd0, new_grid_mux_sel}; end
        8'h08: begin oa = {6'd0, io_mux_addr}; od = {12'd0, new_io_mux_sel}; end
        8'h10, 8'h20: begin oa = {7'd0, rca_result_mux_addr}; od = {13'd0, new_rca_result_mux_sel}; end
        8'h40: begin od = {11'd0, new_rca_io_inp_map}; end
        default: ;
      endcase
      if (exp_q.size() == 0) check_eq("unexpected_write", {s, oa, od, osd}, 32'd0);
      else check_eq("write", {s, oa, od, osd}, exp_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) sample_writes();
  end

  task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [15:0] d);
    int g;
    g = 0;
    while (!ifc.cmd_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 100) check_eq("push_ready_timeout", {31'd0, ifc.cmd_ready}, 32'd1);
    ifc.cmd_valid = 1'b1; ifc.cmd_op = op; ifc.cmd_addr = a; ifc.cmd_data = d;
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
    if (!in_seq) begin
      if (op == 4'd0) in_seq = 1'b1;
      else err_exp = 1'b1;
    end else if (op == 4'd9) begin
      in_seq = 1'b0;
    end else if (op >= 4'd1 && op <= 4'd8) begin
      exp_q.push_back(model_rec(op, a, d));
    end else begin
      err_exp = 1'b1;
    end
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    done_tgt++;
    while (done_cnt < done_tgt && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("done_count", done_cnt, done_tgt);
  endtask

  initial begin
    ifc.cmd_valid = 1'b0; ifc.cmd_op = 4'd0; ifc.cmd_addr = 8'd0; ifc.cmd_data = 16'd0;
    rca_idle = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_strobes", {24'd0, strobes()}, 32'd0);
    check_eq("rst_busy", {28'd0, rca_cfg_busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_ready", {31'd0, ifc.cmd_ready}, 32'd1);
    check_eq("rst_flags", {29'd0, cfg_done, cfg_error, 1'b0}, 32'd0);
    check_eq("rst_sel", {30'd0, cfg_rca_sel}, 32'd0);

    // Basic sequence on RCA 2
    push(OP_START, 8'd2, 16'd0);
    @(posedge clk); #1;
    check_eq("t1_busy", {28'd0, rca_cfg_busy}, 32'h4);
    push(OP_SRC, 8'd1, 16'd7);
    push(OP_DEST_FB, 8'd0, 16'd9);
    push(OP_END, 8'd0, 16'd0);
    wait_done();
    check_eq("t1_busy_clr", {28'd0, rca_cfg_busy}, 32'd0);
    check_eq("t1_sel", {30'd0, cfg_rca_sel}, 32'd2);

    // RCA 1 not idle: FIFO fills, nothing drains until idle rises
    rca_idle = 4'b1101;
    push(OP_START, 8'd1, 16'd0);
    push(OP_SRC, 8'd1, 16'd3);
    push(OP_DEST_NFB, 8'd1, 16'd4);
    push(OP_GRID, 8'd10, 16'd5);
    push(OP_IO, 8'd2, 16'd6);
    check_eq("t2_ready_full", {31'd0, ifc.cmd_ready}, 32'd0);
    check_eq("t2_busy", {28'd0, rca_cfg_busy}, 32'h2);
    snap_wr = wr_cnt;
    repeat (10) @(posedge clk);
    #1;
    check_eq("t2_no_writes", wr_cnt, snap_wr);
    check_eq("t2_no_pops", {31'd0, ifc.cmd_ready}, 32'd0);
    fork
      begin
        repeat (2) @(posedge clk);
        #1;
        rca_idle = 4'hF;
        k_lat = 0;
        while (strobes() == 8'h00 && k_lat < 20) begin
          @(posedge clk); #1;
          k_lat++;
        end
        check_eq("t2_idle_to_wr", k_lat, 2);
      end
      begin
        push(OP_RES_FB, 8'd1, 16'd2);
        push(OP_RES_NFB, 8'd0, 16'd3);
        push(OP_END, 8'd0, 16'd0);
      end
    join
    wait_done();

    // Grid and IO map on the field boundaries
    push(OP_START, 8'd0, 16'd0);
    push(OP_GRID, 8'd63, 16'd15);
    push(OP_IO_MAP, 8'd0, 16'b1010);
    push(OP_END, 8'd0, 16'd0);
    wait_done();
    check_eq("t4_err_clear", {31'd0, cfg_error}, 32'd0);

    // Protocol errors: stray SRC, then illegal opcode mid-sequence
    snap_wr = wr_cnt;
    push(OP_SRC, 8'd1, 16'd7);
    repeat (4) @(posedge clk);
    #1;
    check_eq("t5_err_stray", {31'd0, cfg_error}, {31'd0, err_exp});
    check_eq("t5_no_write", wr_cnt, snap_wr);
    push(OP_START, 8'd3, 16'd0);
    push(4'd12, 8'd1, 16'd1);
    push(OP_GRID, 8'hC5, 16'h00F3);
    push(OP_END, 8'd0, 16'd0);
    wait_done();
    check_eq("t5_err_sticky", {31'd0, cfg_error}, {31'd0, err_exp});
    check_eq("t5_sel", {30'd0, cfg_rca_sel}, 32'd3);

    // Asynchronous reset while streaming
    rca_idle = 4'b0111;
    push(OP_START, 8'd3, 16'd0);
    push(OP_SRC, 8'd0, 16'd1);
    push(OP_DEST_FB, 8'd1, 16'd2);
    push(OP_DEST_NFB, 8'd0, 16'd3);
    push(OP_IO, 8'd1, 16'd4);
    rca_idle = 4'hF;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("t6_streaming", {24'd0, strobes()}, 32'h01);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    in_seq = 1'b0;
    err_exp = 1'b0;
    #1;
    check_eq("t6_rst_strobes", {24'd0, strobes()}, 32'd0);
    check_eq("t6_rst_busy", {28'd0, rca_cfg_busy}, 32'd0);
    check_eq("t6_rst_done", {31'd0, cfg_done}, 32'd0);
    check_eq("t6_rst_ready", {31'd0, ifc.cmd_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    snap_wr = wr_cnt;
    snap_done = done_cnt;
    repeat (10) @(posedge clk);
    #1;
    check_eq("t6_fifo_empty", wr_cnt, snap_wr);
    check_eq("t6_no_done", done_cnt, snap_done);
    check_eq("t6_err_cleared", {31'd0, cfg_error}, 32'd0);

    // Recovery after reset
    push(OP_START, 8'd1, 16'd0);
    push(OP_GRID, 8'd1, 16'd1);
    push(OP_END, 8'd0, 16'd0);
    wait_done();
    check_eq("end_sb_empty", exp_q.size(), 32'd0);
    check_eq("end_busy", {28'd0, rca_cfg_busy}, 32'd0);
    check_eq("end_err", {31'd0, cfg_error}, {31'd0, err_exp});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
